// File: rtl/lm07_pkg.sv
// Shared definitions for the LM07 poll sequencer: FSM encoding, temperature
// width and the signed temperature compare used by the optional alarm.
package lm07_pkg;

  localparam int TEMP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Two's-complement "a > b" on raw temperature codes.
  function automatic logic temp_gt(input logic [TEMP_W-1:0] a,
                                   input logic [TEMP_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage

// File: rtl/lm07_poll_timer.sv
// Free-running poll divider: counts 0..POLL_DIV-1 and flags the terminal count.
module lm07_poll_timer
  import lm07_pkg::*;
#(
  parameter int POLL_DIV = 1000
) (
  input  logic clk,
  input  logic rstn,
  output logic tc
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(POLL_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lm07_poll_sched.sv
// LM07 read sequencer: periodic/host-triggered SPI reads with timeout supervision.
// Optional over-temperature alarm with hysteresis enabled by `define LM07_ALARM_EN.
module lm07_poll_sched
  import lm07_pkg::*;
#(
  parameter int POLL_DIV = 1000,
  parameter int TIMEOUT  = 256
) (
  input  logic              SYSCLK,
  input  logic              RSTN,
  input  logic              host_req,
  output logic              host_ack,
  output logic              rd_start,
  input  logic              rd_done,
  input  logic [TEMP_W-1:0] rd_data,
  output logic [TEMP_W-1:0] sample,
  output logic              sample_valid,
  output logic              sample_new,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
`ifdef LM07_ALARM_EN
  ,
  input  logic [TEMP_W-1:0] thr_hi,
  input  logic [TEMP_W-1:0] thr_lo,
  output logic              alarm
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic              poll_tc;
  logic              poll_pend;
  logic              host_pend;
  logic              serve_host;
  logic [TW-1:0]     tmo_cnt;
  logic [TEMP_W-1:0] cap;
  logic              fire;
  logic              tmo_hit;

  lm07_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_timer (
    .clk (SYSCLK),
    .rstn(RSTN),
    .tc  (poll_tc)
  );

  assign fire    = (state == ST_IDLE) && (poll_pend || host_pend);
  assign tmo_hit = (state == ST_WAIT) && !rd_done && (tmo_cnt == TW'(TIMEOUT));

  // A request in the accept cycle re-arms its flag so it is served next.
  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      poll_pend <= 1'b0;
      host_pend <= 1'b0;
    end else begin
      poll_pend <= poll_tc  | (poll_pend & ~fire);
      host_pend <= host_req | (host_pend & ~fire);
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      timeout_err <= 1'b0;
    end else if (tmo_hit) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (state == ST_WAIT && rd_done) begin
      cap <= rd_data;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      state        <= ST_IDLE;
      serve_host   <= 1'b0;
      tmo_cnt      <= '0;
      rd_start     <= 1'b0;
      busy         <= 1'b0;
      host_ack     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_new   <= 1'b0;
    end else begin
      rd_start   <= 1'b0;
      host_ack   <= 1'b0;
      sample_new <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            serve_host <= host_pend;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          rd_start <= 1'b1;
          tmo_cnt  <= TW'(1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // rd_done takes priority over an expiring timeout in the same cycle
          if (rd_done) begin
            state <= ST_LATCH;
          end else if (tmo_hit) begin
            host_ack <= serve_host;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_LATCH: begin
          sample       <= cap;
          sample_valid <= 1'b1;
          sample_new   <= 1'b1;
          host_ack     <= serve_host;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LM07_ALARM_EN
  // Hysteresis: set above thr_hi, clear below thr_lo, otherwise hold.
  always_ff @(posedge SYSCLK) begin
    if (!RSTN) begin
      alarm <= 1'b0;
    end else if (state == ST_LATCH) begin
      if (temp_gt(cap, thr_hi)) begin
        alarm <= 1'b1;
      end else if (temp_gt(thr_lo, cap)) begin
        alarm <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lm07_poll_sched.sv
// Bench for lm07_poll_sched: directed vectors plus randomized traffic scored
// against a timestamp-based transaction model.
module tb_lm07_poll_sched;

  localparam int PD = 20;
  localparam int TO = 16;

  logic SYSCLK = 1'b0;
  logic RSTN = 1'b0;
  logic host_req = 1'b0;
  logic err_clr = 1'b0;
  logic rdr_done = 1'b0;
  logic man_done = 1'b0;
  logic [7:0] rdr_data = 8'h00;
  logic [7:0] man_data = 8'h00;
  logic rd_done;
  logic [7:0] rd_data;
  logic host_ack, rd_start, sample_valid, sample_new, busy, timeout_err;
  logic [7:0] sample;
`ifdef LM07_ALARM_EN
  logic [7:0] thr_hi = 8'h28;
  logic [7:0] thr_lo = 8'h20;
  logic alarm;
`endif

  assign rd_done = rdr_done | man_done;
  assign rd_data = man_done ? man_data : rdr_data;

  lm07_poll_sched #(.POLL_DIV(PD), .TIMEOUT(TO)) dut (
    .SYSCLK      (SYSCLK),
    .RSTN        (RSTN),
    .host_req    (host_req),
    .host_ack    (host_ack),
    .rd_start    (rd_start),
    .rd_done     (rd_done),
    .rd_data     (rd_data),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_new  (sample_new),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
`ifdef LM07_ALARM_EN
    ,
    .thr_hi      (thr_hi),
    .thr_lo      (thr_lo),
    .alarm       (alarm)
`endif
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  // Reader stub: answers rsp_lat cycles after rd_start (0 = never answers).
  bit rd_en = 1'b1;
  bit rand_rsp = 1'b0;
  int rsp_lat = 5;
  logic [7:0] rsp_data = 8'h19;

  initial begin : reader
    int lat;
    logic [7:0] dat;
    forever begin
      @(negedge SYSCLK);
      if (rd_en && rd_start === 1'b1) begin
        if (rand_rsp) begin
          lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 18));
          dat = 8'($urandom);
        end else begin
          lat = rsp_lat;
          dat = rsp_data;
        end
        if (lat > 0) begin
          repeat (lat - 1) @(negedge SYSCLK);
          rdr_data = dat;
          rdr_done = 1'b1;
          @(negedge SYSCLK);
          rdr_done = 1'b0;
        end
      end
    end
  end

  // Reference model: a transaction is decided at edge d, starts at d+1 (=s),
  // may complete at any edge in (s, s+TO]; the result lands one edge later.
  logic s_rst, s_host, s_done, s_clr;
  logic [7:0] s_data;
  bit s_tick = 1'b0;

  always @(posedge SYSCLK) begin
    s_rst  <= RSTN;
    s_host <= host_req;
    s_done <= rd_done;
    s_clr  <= err_clr;
    s_data <= rd_data;
    s_tick <= 1'b1;
  end

  int m_k = 0, m_pc = 0, m_s = 0, m_de = -1;
  bit m_pp, m_hp, m_busy, m_serve, m_start, m_ack, m_new, m_valid, m_err, m_alarm;
  bit started = 1'b0;
  logic [7:0] m_sample, m_cap;

  task automatic model_step();
    bit tc, fire, eset;
    m_k++;
    if (!s_rst) begin
      started = 1'b1;
      m_pc = 0; m_pp = 0; m_hp = 0; m_busy = 0; m_serve = 0;
      m_start = 0; m_ack = 0; m_new = 0; m_valid = 0; m_err = 0; m_alarm = 0;
      m_sample = 8'h00; m_de = -1;
      return;
    end
    m_start = 0; m_ack = 0; m_new = 0; eset = 0;
    tc = (m_pc == PD - 1);
    m_pc = tc ? 0 : m_pc + 1;
    fire = !m_busy && (m_pp || m_hp);
    if (fire) begin
      m_serve = m_hp; m_s = m_k + 1; m_de = -1; m_busy = 1;
    end else if (m_busy) begin
      if (m_k == m_s) begin
        m_start = 1;
      end else if (m_de < 0) begin
        if (s_done) begin
          m_de = m_k; m_cap = s_data;
        end else if (m_k == m_s + TO) begin
          eset = 1; m_ack = m_serve; m_busy = 0;
        end
      end else begin
        m_sample = m_cap; m_valid = 1; m_new = 1; m_ack = m_serve; m_busy = 0;
`ifdef LM07_ALARM_EN
        if ($signed(m_cap) > $signed(thr_hi)) m_alarm = 1;
        else if ($signed(m_cap) < $signed(thr_lo)) m_alarm = 0;
`endif
      end
    end
    m_pp = tc || (m_pp && !fire);
    m_hp = s_host || (m_hp && !fire);
    if (eset) m_err = 1;
    else if (s_clr) m_err = 0;
  endtask

  always @(negedge SYSCLK) begin
    if (s_tick) begin
      model_step();
      if (started) begin
        chk("mon_rd_start", 32'(rd_start), 32'(m_start));
        chk("mon_busy", 32'(busy), 32'(m_busy));
        chk("mon_host_ack", 32'(host_ack), 32'(m_ack));
        chk("mon_sample", 32'(sample), 32'(m_sample));
        chk("mon_sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("mon_sample_new", 32'(sample_new), 32'(m_new));
        chk("mon_timeout_err", 32'(timeout_err), 32'(m_err));
`ifdef LM07_ALARM_EN
        chk("mon_alarm", 32'(alarm), 32'(m_alarm));
`endif
      end
    end
  end

  task automatic wait_start(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge SYSCLK);
      if (rd_start) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int lim, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    while (!done && n < lim) begin
      @(negedge SYSCLK);
      n++;
      if (!busy) done = 1'b1;
    end
  endtask

  typedef struct {
    int         lat;
    logic [7:0] data;
    logic [7:0] exp_sample;
    bit         exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin : main
    bit ok;
    int n, nst, nack, nnew, prev;
    int starts[$];
    logic [7:0] av[4];
    bit aexp[4];

    vecs[0] = '{lat: 5,  data: 8'h19, exp_sample: 8'h19, exp_err: 1'b0, exp_cyc: 6};
    vecs[1] = '{lat: 0,  data: 8'h55, exp_sample: 8'h19, exp_err: 1'b1, exp_cyc: 16};
    vecs[2] = '{lat: 16, data: 8'h42, exp_sample: 8'h42, exp_err: 1'b0, exp_cyc: 17};
    vecs[3] = '{lat: 1,  data: 8'h80, exp_sample: 8'h80, exp_err: 1'b0, exp_cyc: 2};
    vecs[4] = '{lat: 2,  data: 8'h7F, exp_sample: 8'h7F, exp_err: 1'b0, exp_cyc: 3};
    vecs[5] = '{lat: 0,  data: 8'h01, exp_sample: 8'h7F, exp_err: 1'b1, exp_cyc: 16};

    // Reset state
    tick(3);
    chk("rst_sample", 32'(sample), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_start", 32'(rd_start), 32'h0);
    chk("rst_host_ack", 32'(host_ack), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    RSTN = 1'b1;

    // Periodic poll
    nnew = 0; nack = 0;
    for (int i = 0; i < 110; i++) begin
      tick(1);
      if (rd_start) starts.push_back(i);
      if (sample_new) nnew++;
      if (host_ack) nack++;
    end
    chk("poll_count", 32'(starts.size()), 32'd5);
    if (starts.size() > 0) chk("poll_first", 32'(starts[0]), 32'd21);
    for (int i = 1; i < starts.size(); i++) chk("poll_spacing", 32'(starts[i] - starts[i-1]), 32'd20);
    chk("poll_new_count", 32'(nnew), 32'd5);
    chk("poll_no_ack", 32'(nack), 32'd0);
    chk("poll_sample", 32'(sample), 32'h19);
    chk("poll_valid", 32'(sample_valid), 32'h1);

    // Host request merge during a busy poll transaction
    rsp_data = 8'hE7;
    wait_start(40, ok);
    chk("merge_start_seen", 32'(ok), 32'd1);
    host_req = 1'b1; tick(1); host_req = 1'b0; tick(1);
    host_req = 1'b1; tick(1); host_req = 1'b0;
    nst = 0; nack = 0; nnew = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (rd_start) nst++;
      if (host_ack) begin
        nack++;
        chk("merge_ack_with_new", 32'(sample_new), 32'd1);
      end
    end
    chk("merge_one_txn", 32'(nst), 32'd1);
    chk("merge_one_ack", 32'(nack), 32'd1);
    chk("merge_sample", 32'(sample), 32'hE7);

    // Table: reader latency / data / expected outcome
    foreach (vecs[v]) begin
      rsp_lat = vecs[v].lat;
      rsp_data = vecs[v].data;
      wait_start(40, ok);
      chk("vec_start_seen", 32'(ok), 32'd1);
      wait_idle(40, n);
      chk($sformatf("vec%0d_cycles", v), 32'(n), 32'(vecs[v].exp_cyc));
      chk($sformatf("vec%0d_sample", v), 32'(sample), 32'(vecs[v].exp_sample));
      chk($sformatf("vec%0d_err", v), 32'(timeout_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_valid", v), 32'(sample_valid), 32'd1);
      err_clr = 1'b1; tick(1); err_clr = 1'b0;
      chk($sformatf("vec%0d_err_clr", v), 32'(timeout_err), 32'd0);
    end

    // Poll terminal count and host request in the same cycle
    rsp_lat = 5;
    rsp_data = 8'h19;
    wait_start(40, ok);
    chk("simul_start_seen", 32'(ok), 32'd1);
    tick(17);
    host_req = 1'b1; tick(1); host_req = 1'b0;
    nst = 0; nack = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (rd_start) nst++;
      if (host_ack) nack++;
    end
    chk("simul_one_txn", 32'(nst), 32'd1);
    chk("simul_one_ack", 32'(nack), 32'd1);

    // Reset in WAIT, then a late rd_done
    rd_en = 1'b0;
    wait_start(40, ok);
    chk("rstw_start_seen", 32'(ok), 32'd1);
    tick(3);
    chk("rstw_busy_before", 32'(busy), 32'd1);
    RSTN = 1'b0; tick(1); RSTN = 1'b1;
    man_data = 8'h30; man_done = 1'b1; tick(1); man_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstw_sample", 32'(sample), 32'h0);
      chk("rstw_valid", 32'(sample_valid), 32'h0);
      chk("rstw_busy", 32'(busy), 32'h0);
      chk("rstw_ack", 32'(host_ack), 32'h0);
      tick(1);
    end
    rd_en = 1'b1;

`ifdef LM07_ALARM_EN
    // Alarm hysteresis
    av[0] = 8'h27; av[1] = 8'h29; av[2] = 8'h22; av[3] = 8'h1F;
    aexp[0] = 1'b0; aexp[1] = 1'b1; aexp[2] = 1'b1; aexp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_data = av[i];
      wait_start(40, ok);
      chk("alarm_start_seen", 32'(ok), 32'd1);
      wait_idle(40, n);
      chk($sformatf("alarm%0d", i), 32'(alarm), 32'(aexp[i]));
    end
`else
    av[0] = 8'h00;
    aexp[0] = 1'b0;
`endif

    // Randomized traffic scored by the model
    rand_rsp = 1'b1;
    for (int i = 0; i < 900; i++) begin
      host_req = ($urandom_range(0, 9) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      man_done = ($urandom_range(0, 39) == 0);
      man_data = 8'($urandom);
      RSTN     = !($urandom_range(0, 399) == 0);
      tick(1);
    end
    host_req = 1'b0; err_clr = 1'b0; man_done = 1'b0; RSTN = 1'b1;
    tick(5);

    prev = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lm07_poll_sched.md
# lm07_poll_sched

Sequencer for the LM07 SPI read datapath. It decides when the existing serial reader runs a transaction: either on a periodic poll timer or on a host on-demand request. It drives the reader through a start/done handshake, supervises each transaction with a timeout, and holds the most recent temperature sample for the display and host logic.

## Interface
- `POLL_DIV`, 1000: SYSCLK cycles between periodic poll requests. Must be ≥ 2.
- `TIMEOUT`, 256: maximum SYSCLK cycles spent waiting for `rd_done` after `rd_start`. Must be ≥ 2.
- `SYSCLK`, in, 1: the only clock. All logic is on the rising edge.
- `RSTN`, in, 1: reset, synchronous, active-low.
- `host_req`, in, 1: level or pulse. Registers one pending on-demand read.
- `host_ack`, out, 1: one-cycle pulse when the transaction serving a host request ends, whether it succeeds or times out.
- `rd_start`, out, 1: one-cycle pulse that starts one transaction in the SPI reader.
- `rd_done`, in, 1: one-cycle pulse from the reader. `rd_data` is valid in the same cycle.
- `rd_data`, in, 8: two's-complement temperature in °C.
- `sample`, out, 8: last good temperature.
- `sample_valid`, out, 1: set after the first good sample; sticky until reset.
- `sample_new`, out, 1: one-cycle pulse in the cycle after `sample` updates.
- `busy`, out, 1: high while a transaction is outstanding.
- `timeout_err`, out, 1: sticky error flag. Cleared by `err_clr`.
- `err_clr`, in, 1: clears `timeout_err`.
- `thr_hi`, in, 8: signed alarm set threshold. Present only with `LM07_ALARM_EN`.
- `thr_lo`, in, 8: signed alarm clear threshold. Present only with `LM07_ALARM_EN`.
- `alarm`, out, 1: over-temperature flag. Present only with `LM07_ALARM_EN`.

## Operation
- **Poll counter.** Free-runs 0 … `POLL_DIV`-1. At the terminal count it sets `poll_pend` and wraps to 0. It keeps counting while a transaction is busy.
- **Host request.** `host_req`=1 sets `host_pend`. Extra requests while `host_pend` is already set are merged into it.
- **State IDLE.** If `poll_pend` or `host_pend` is set, go to START. Latch `serve_host` = `host_pend`, then clear both pending flags. Requests arriving in that same cycle set their flag again and are served next.
- **State START.** Assert `rd_start` for one cycle, load the timeout counter, then go to WAIT.
- **State WAIT.**
  - On `rd_done`: go to LATCH and capture `rd_data`.
  - If the counter reaches `TIMEOUT` without `rd_done`: set `timeout_err`, pulse `host_ack` if `serve_host` is set, and go to IDLE. `sample` is not changed.
  - If `rd_done` and timeout occur in the same cycle, `rd_done` wins.
- **State LATCH.** Update `sample`, set `sample_valid`, pulse `sample_new`, pulse `host_ack` if `serve_host` is set, then go to IDLE.
- `rd_done` seen outside WAIT is ignored.
- **Error clear vs. new error.** If `err_clr` and a new timeout occur in the same cycle, the set wins.

## Timing
- **Reset values.** All outputs are 0: `sample`=8'h00, `busy`=0, all flags 0. The FSM is in IDLE, the poll counter is 0, both pending flags are 0.
- **Reset mid-transaction.** Abandons the transaction without issuing an ack. A late `rd_done` is ignored because the FSM is in IDLE.
- **Request to start.** `host_req` sampled high at edge N means `rd_start` is high in cycle N+2 (pending set at N, IDLE→START at N+1).
- **Done to sample.** `rd_done` at edge M means `sample` is updated at M+1, and `sample_new` and `host_ack` are high during cycle M+1→M+2.
- **`busy`.** High from START through LATCH. Low in IDLE.
- **Back-to-back.** Minimum spacing between two `rd_start` pulses is 4 cycles (START, WAIT, LATCH, IDLE), plus the reader's own latency.

## Configuration
- **`LM07_ALARM_EN` defined.** Adds `thr_hi`, `thr_lo` and `alarm`.
  - At LATCH, with signed comparison: the new sample > `thr_hi` sets `alarm`; the new sample < `thr_lo` clears it.
  - Otherwise `alarm` holds its value (hysteresis).
  - `alarm` resets to 0.
- **`LM07_ALARM_EN` undefined.** These ports and the comparator logic do not exist. Everything else is unchanged.

## Structure
- **Shared package `lm07_pkg`** holds:
  - the FSM state encoding (IDLE=0, START=1, WAIT=2, LATCH=3);
  - the temperature width constant (8);
  - the signed-compare helper function.
- **Sub-module `lm07_poll_timer`** contains the poll counter and terminal-count pulse, parameterised by `POLL_DIV`.
- The FSM, pending flags, timeout counter and sample/alarm registers stay in the top module.

## Test plan
- **Periodic poll.** `POLL_DIV`=20 and the reader model answers 5 cycles after start with 8'h19 → `rd_start` every 20 cycles; `sample`=8'h19; `sample_valid`=1; one `sample_new` per poll; `host_ack` never asserted.
- **Host request and merge.** Pulse `host_req`, then pulse it again 2 cycles later, reader returns 8'hE7 → exactly one transaction; `sample`=8'hE7 (−25 °C); exactly one `host_ack`, in the same cycle as `sample_new`.
- **Timeout.** `TIMEOUT`=16 and the reader never answers → `timeout_err`=1 after 16 WAIT cycles; `sample` keeps its old value; FSM back in IDLE; `err_clr` pulse → `timeout_err`=0; the next poll succeeds.
- **Simultaneous events.** Poll terminal count and `host_req` in the same cycle → one transaction with `host_ack`. `rd_done` on the timeout cycle → sample accepted, `timeout_err` stays 0.
- **Reset mid-WAIT.** Drop `RSTN` for 1 cycle during WAIT, then drive a late `rd_done` with 8'h30 → all outputs 0, `sample` stays 8'h00, no `host_ack`.
- **Alarm (`LM07_ALARM_EN`).** `thr_hi`=8'h28, `thr_lo`=8'h20; samples 8'h27, 8'h29, 8'h22, 8'h1F → `alarm` = 0, 1, 1, 0.
